// File: rtl/bp_lce_req_queue.sv
// Queued LCE request issuer: buffers cache miss/uncached requests, emits BedRock LCE
// request headers and data beats under a credit limit. Optional stats: BP_LCE_REQ_STATS_EN.
module bp_lce_req_queue
  #(parameter int paddr_width_p    = 40
  , parameter int lce_id_width_p   = 8
  , parameter int cce_id_width_p   = 6
  , parameter int num_cce_p        = 1
  , parameter int assoc_p          = 8
  , parameter int sets_p           = 64
  , parameter int block_width_p    = 512
  , parameter int fill_width_p     = 64
  , parameter int queue_els_p      = 2
  , parameter int credits_p        = 16
  , parameter bit non_excl_reads_p = 1'b0
  , localparam int lce_assoc_width_lp      = (assoc_p > 1) ? $clog2(assoc_p) : 1
  , localparam int cache_req_width_lp      = 4 + 4 + 3 + paddr_width_p + 64
  , localparam int lce_req_header_width_lp = 4 + 4 + paddr_width_p + 3 + cce_id_width_p
                                             + lce_id_width_p + lce_assoc_width_lp + 1
  )
  (input  logic                                clk_i
  , input  logic                               reset_n_i
  , input  logic [lce_id_width_p-1:0]          lce_id_i
  , input  logic                               cache_init_done_i
  , input  logic [cache_req_width_lp-1:0]      cache_req_i
  , input  logic [lce_assoc_width_lp-1:0]      cache_req_way_i
  , input  logic                               cache_req_v_i
  , output logic                               cache_req_ready_and_o
  , input  logic                               cache_req_complete_i
  , input  logic                               uc_store_req_complete_i
  , output logic                               credits_full_o
  , output logic                               credits_empty_o
  , output logic                               queue_empty_o
  , output logic [lce_req_header_width_lp-1:0] lce_req_header_o
  , output logic                               lce_req_header_v_o
  , input  logic                               lce_req_header_ready_and_i
  , output logic                               lce_req_has_data_o
  , output logic [fill_width_p-1:0]            lce_req_data_o
  , output logic                               lce_req_data_v_o
  , input  logic                               lce_req_data_ready_and_i
  , output logic                               lce_req_last_o
`ifdef BP_LCE_REQ_STATS_EN
  , output logic [31:0]                        stat_req_sent_o
  , output logic [31:0]                        stat_credit_stall_o
`endif
  );

  // cache_req_i packing (MSB..LSB): msg_type[4], subop[4], size[3], addr, data[64]
  // header packing (MSB..LSB): non_exclusive, lru_way_id, src_id, dst_id, size[3], addr, subop[4], msg_type[4]
  localparam logic [3:0] req_miss_store_lp = 4'd0;
  localparam logic [3:0] req_miss_load_lp  = 4'd1;
  localparam logic [3:0] req_uc_store_lp   = 4'd2;
  localparam logic [3:0] req_uc_load_lp    = 4'd3;
  localparam logic [3:0] req_uc_amo_lp     = 4'd4;

  localparam logic [3:0] lce_rd_miss_lp = 4'd0;
  localparam logic [3:0] lce_wr_miss_lp = 4'd1;
  localparam logic [3:0] lce_uc_rd_lp   = 4'd2;
  localparam logic [3:0] lce_uc_wr_lp   = 4'd3;
  localparam logic [3:0] lce_uc_amo_lp  = 4'd4;

  localparam int         block_offset_lp = $clog2(block_width_p / 8);
  localparam logic [2:0] block_size_lp   = 3'(block_offset_lp);
  localparam int         cce_sel_w_lp    = (num_cce_p > 1) ? $clog2(num_cce_p) : 1;
  localparam int         ptr_w_lp        = (queue_els_p > 1) ? $clog2(queue_els_p) : 1;
  localparam int         qcnt_w_lp       = $clog2(queue_els_p + 1);
  localparam int         cred_w_lp       = $clog2(credits_p + 1);
  localparam int         entry_w_lp      = lce_assoc_width_lp + cache_req_width_lp;

  if (fill_width_p < 8 || fill_width_p > block_width_p || (fill_width_p & (fill_width_p - 1)) != 0)
    begin : bad_fill_width
      $error("fill_width_p must be a power of 2 between 8 and block_width_p");
    end
  if (sets_p < 1 || queue_els_p < 1 || (queue_els_p & (queue_els_p - 1)) != 0 || credits_p < 1)
    begin : bad_geometry
      $error("sets_p, credits_p must be >= 1 and queue_els_p a power of 2");
    end

  typedef enum logic [1:0] {e_reset, e_ready, e_data} state_e;
  state_e state_r;

  function automatic logic [ptr_w_lp-1:0] next_ptr(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(queue_els_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  function automatic logic [cce_id_width_p-1:0] addr_to_cce_id(input logic [paddr_width_p-1:0] a);
    if (num_cce_p > 1) return cce_id_width_p'(a[block_offset_lp +: cce_sel_w_lp]);
    else               return '0;
  endfunction

  // Cache AMO subops share encodings with BedRock amolr..amomaxu; anything else is a store
  function automatic logic [3:0] map_amo_subop(input logic [3:0] s);
    return (s >= 4'd1 && s <= 4'd11) ? s : 4'd0;
  endfunction

  // Request queue
  logic [entry_w_lp-1:0] mem_r [queue_els_p];
  logic [ptr_w_lp-1:0]   wr_ptr_r, rd_ptr_r;
  logic [qcnt_w_lp-1:0]  q_cnt_r;
  logic                  push, pop, q_full;

  assign q_full                = (q_cnt_r == qcnt_w_lp'(queue_els_p));
  assign queue_empty_o         = (q_cnt_r == '0);
  assign cache_req_ready_and_o = (state_r != e_reset) & ~q_full;
  assign push                  = cache_req_v_i & cache_req_ready_and_o;

  always_ff @(posedge clk_i) begin
    if (push) mem_r[wr_ptr_r] <= {cache_req_way_i, cache_req_i};
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      q_cnt_r  <= '0;
    end else begin
      if (push) wr_ptr_r <= next_ptr(wr_ptr_r);
      if (pop)  rd_ptr_r <= next_ptr(rd_ptr_r);
      if (push && !pop)      q_cnt_r <= q_cnt_r + qcnt_w_lp'(1);
      else if (pop && !push) q_cnt_r <= q_cnt_r - qcnt_w_lp'(1);
    end
  end

  // Head decode
  logic [entry_w_lp-1:0]         head;
  logic [lce_assoc_width_lp-1:0] head_way;
  logic [3:0]                    head_type, head_subop;
  logic [2:0]                    head_size;
  logic [paddr_width_p-1:0]      head_addr;
  logic [63:0]                   head_data;

  assign head       = mem_r[rd_ptr_r];
  assign head_data  = head[63:0];
  assign head_addr  = head[64 +: paddr_width_p];
  assign head_size  = head[64+paddr_width_p +: 3];
  assign head_subop = head[67+paddr_width_p +: 4];
  assign head_type  = head[71+paddr_width_p +: 4];
  assign head_way   = head[cache_req_width_lp +: lce_assoc_width_lp];

  logic [3:0]                    hdr_type, hdr_subop;
  logic [2:0]                    hdr_size;
  logic [paddr_width_p-1:0]      hdr_addr;
  logic [lce_assoc_width_lp-1:0] hdr_way;
  logic                          hdr_nonexcl, hdr_has_data;

  always_comb begin
    hdr_type     = lce_uc_rd_lp;
    hdr_subop    = 4'd0;
    hdr_size     = head_size;
    hdr_addr     = head_addr;
    hdr_way      = '0;
    hdr_nonexcl  = 1'b0;
    hdr_has_data = 1'b0;
    case (head_type)
      req_miss_load_lp, req_miss_store_lp: begin
        hdr_type    = (head_type == req_miss_load_lp) ? lce_rd_miss_lp : lce_wr_miss_lp;
        hdr_size    = block_size_lp;
        hdr_addr    = head_addr & ~paddr_width_p'(fill_width_p / 8 - 1);
        hdr_way     = head_way;
        hdr_nonexcl = (head_type == req_miss_load_lp) ? non_excl_reads_p : 1'b0;
      end
      req_uc_store_lp: begin
        hdr_type     = lce_uc_wr_lp;
        hdr_has_data = 1'b1;
      end
      req_uc_amo_lp: begin
        hdr_type     = lce_uc_amo_lp;
        hdr_subop    = map_amo_subop(head_subop);
        hdr_has_data = 1'b1;
      end
      default: hdr_type = lce_uc_rd_lp;
    endcase
  end

  // Beat count and selection
  int         n_beats, beat_idx;
  logic [2:0] beat_cnt_r, last_idx;
  logic [fill_width_p-1:0] beat_data;

  always_comb begin
    n_beats = (8 << head_size) / fill_width_p;
    if (n_beats < 1) n_beats = 1;
    last_idx = 3'(n_beats - 1);
  end

  if (fill_width_p >= 64) begin : g_rep
    assign beat_idx  = 0;
    assign beat_data = {(fill_width_p / 64){head_data}};
  end else begin : g_slice
    assign beat_idx  = int'(beat_cnt_r) % (64 / fill_width_p);
    assign beat_data = head_data[beat_idx*fill_width_p +: fill_width_p];
  end

  // Credits and handshakes
  logic [cred_w_lp-1:0] credit_cnt_r;
  logic                 hdr_hs, data_hs, data_last, ret_v;

  assign credits_full_o  = (credit_cnt_r == cred_w_lp'(credits_p));
  assign credits_empty_o = (credit_cnt_r == '0);
  assign ret_v           = cache_req_complete_i | uc_store_req_complete_i;

  assign lce_req_header_v_o = (state_r == e_ready) & ~queue_empty_o & ~credits_full_o;
  assign lce_req_data_v_o   = (state_r == e_data);
  assign hdr_hs             = lce_req_header_v_o & lce_req_header_ready_and_i;
  assign data_last          = (beat_cnt_r == last_idx);
  assign data_hs            = lce_req_data_v_o & lce_req_data_ready_and_i;
  assign pop                = (hdr_hs & ~hdr_has_data) | (data_hs & data_last);

  assign lce_req_header_o   = lce_req_header_v_o
    ? {hdr_nonexcl, hdr_way, lce_id_i, addr_to_cce_id(head_addr), hdr_size, hdr_addr, hdr_subop, hdr_type}
    : '0;
  assign lce_req_has_data_o = lce_req_header_v_o & hdr_has_data;
  assign lce_req_data_o     = lce_req_data_v_o ? beat_data : '0;
  assign lce_req_last_o     = (lce_req_header_v_o & ~hdr_has_data) | (lce_req_data_v_o & data_last);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      credit_cnt_r <= '0;
    end else if (hdr_hs && !ret_v) begin
      credit_cnt_r <= credit_cnt_r + cred_w_lp'(1);
    end else if (!hdr_hs && ret_v && credit_cnt_r != '0) begin
      credit_cnt_r <= credit_cnt_r - cred_w_lp'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r    <= e_reset;
      beat_cnt_r <= '0;
    end else begin
      case (state_r)
        e_reset: if (cache_init_done_i) state_r <= e_ready;
        e_ready: if (hdr_hs && hdr_has_data) begin
          state_r    <= e_data;
          beat_cnt_r <= '0;
        end
        e_data: if (data_hs) begin
          if (data_last) state_r <= e_ready;
          else           beat_cnt_r <= beat_cnt_r + 3'd1;
        end
        default: state_r <= e_reset;
      endcase
    end
  end

`ifdef BP_LCE_REQ_STATS_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stat_req_sent_o     <= '0;
      stat_credit_stall_o <= '0;
    end else begin
      if (hdr_hs && stat_req_sent_o != '1)
        stat_req_sent_o <= stat_req_sent_o + 32'd1;
      if (!queue_empty_o && credits_full_o && stat_credit_stall_o != '1)
        stat_credit_stall_o <= stat_credit_stall_o + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  logic [3:0] in_type;
  logic [2:0] in_size;
  assign in_type = cache_req_i[71+paddr_width_p +: 4];
  assign in_size = cache_req_i[64+paddr_width_p +: 3];

  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(ret_v && !hdr_hs && credit_cnt_r == '0))
        else $error("credit return with no outstanding requests");
      assert (!(push && (in_type == req_uc_store_lp || in_type == req_uc_load_lp
                         || in_type == req_uc_amo_lp) && in_size > 3'd3))
        else $error("uncached request larger than 8 bytes");
    end
  end
`endif

endmodule

// File: tb/tb_bp_lce_req_queue.sv
// Directed bench for bp_lce_req_queue: fill_width_p=32, credits_p=2, queue_els_p=2, 4 CCEs.
module tb_bp_lce_req_queue;
  localparam int PADDR = 40;
  localparam int LCEW  = 8;
  localparam int CCEW  = 6;
  localparam int WAYW  = 3;
  localparam int FILL  = 32;
  localparam int REQW  = 4 + 4 + 3 + PADDR + 64;
  localparam int HDRW  = 4 + 4 + PADDR + 3 + CCEW + LCEW + WAYW + 1;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [LCEW-1:0] lce_id;
  logic            init_done;
  logic [REQW-1:0] req;
  logic [WAYW-1:0] way;
  logic            req_v, req_ready;
  logic            comp, ucomp;
  logic            cred_full, cred_empty, q_empty;
  logic [HDRW-1:0] hdr;
  logic            hdr_v, hdr_ready, has_data;
  logic [FILL-1:0] data;
  logic            data_v, data_ready, last;
`ifdef BP_LCE_REQ_STATS_EN
  logic [31:0]     stat_sent, stat_stall;
`endif

  int total  = 0;
  int passed = 0;

  bp_lce_req_queue #(
    .paddr_width_p(PADDR), .lce_id_width_p(LCEW), .cce_id_width_p(CCEW), .num_cce_p(4),
    .assoc_p(8), .sets_p(64), .block_width_p(512), .fill_width_p(FILL),
    .queue_els_p(2), .credits_p(2), .non_excl_reads_p(1'b1)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .lce_id_i(lce_id), .cache_init_done_i(init_done),
    .cache_req_i(req), .cache_req_way_i(way), .cache_req_v_i(req_v),
    .cache_req_ready_and_o(req_ready), .cache_req_complete_i(comp),
    .uc_store_req_complete_i(ucomp), .credits_full_o(cred_full), .credits_empty_o(cred_empty),
    .queue_empty_o(q_empty), .lce_req_header_o(hdr), .lce_req_header_v_o(hdr_v),
    .lce_req_header_ready_and_i(hdr_ready), .lce_req_has_data_o(has_data),
    .lce_req_data_o(data), .lce_req_data_v_o(data_v), .lce_req_data_ready_and_i(data_ready),
    .lce_req_last_o(last)
`ifdef BP_LCE_REQ_STATS_EN
    , .stat_req_sent_o(stat_sent), .stat_credit_stall_o(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [REQW-1:0] mk_req(input logic [3:0] t, input logic [3:0] sub,
      input logic [2:0] sz, input logic [PADDR-1:0] a, input logic [63:0] d);
    return {t, sub, sz, a, d};
  endfunction

  function automatic logic [HDRW-1:0] mk_hdr(input logic [3:0] t, input logic [3:0] sub,
      input logic [PADDR-1:0] a, input logic [2:0] sz, input logic [CCEW-1:0] dst,
      input logic [WAYW-1:0] w, input logic nx);
    return {nx, w, 8'h5A, dst, sz, a, sub, t};
  endfunction

  initial begin
    reset_n = 1'b0; lce_id = 8'h5A; init_done = 1'b0; req = '0; way = '0; req_v = 1'b0;
    comp = 1'b0; ucomp = 1'b0; hdr_ready = 1'b0; data_ready = 1'b0;
    #3;
    chk("rst_ready", req_ready, 0);
    chk("rst_hdr_v", hdr_v, 0);
    chk("rst_data_v", data_v, 0);
    chk("rst_hdr", hdr, 0);
    chk("rst_data", data, 0);
    chk("rst_cred_empty", cred_empty, 1);
    chk("rst_cred_full", cred_full, 0);
    chk("rst_q_empty", q_empty, 1);
    step(); step();
    reset_n = 1'b1;

    // Miss load held while init is low
    req = mk_req(4'd1, 4'd0, 3'd3, 40'h80_0000_12F6, 64'h0); way = 3'd3; req_v = 1'b1;
    repeat (5) begin
      step();
      chk("ready_init_low", req_ready, 0);
    end
    chk("q_empty_init_low", q_empty, 1);
    init_done = 1'b1;
    step();
    chk("ready_after_init", req_ready, 1);
    chk("no_hdr_yet", hdr_v, 0);
    step();
    req_v = 1'b0;
    chk("miss_hdr_v", hdr_v, 1);
    chk("miss_hdr", hdr, mk_hdr(4'd0, 4'd0, 40'h80_0000_12F4, 3'd6, 6'd3, 3'd3, 1'b1));
    chk("miss_has_data", has_data, 0);
    chk("miss_last", last, 1);
    step();
    chk("miss_hdr_hold", hdr, mk_hdr(4'd0, 4'd0, 40'h80_0000_12F4, 3'd6, 6'd3, 3'd3, 1'b1));
    hdr_ready = 1'b1;
    step();
    hdr_ready = 1'b0;
    chk("miss_popped_hdr_v", hdr_v, 0);
    chk("miss_popped_q_empty", q_empty, 1);
    chk("one_credit_empty", cred_empty, 0);
    chk("one_credit_full", cred_full, 0);

    // Uncached 8B store, two 32-bit beats
    req = mk_req(4'd2, 4'd0, 3'd3, 40'h1008, 64'h1122_3344_5566_7788); req_v = 1'b1;
    step();
    req_v = 1'b0;
    chk("ucst_hdr", hdr, mk_hdr(4'd3, 4'd0, 40'h1008, 3'd3, 6'd0, 3'd0, 1'b0));
    chk("ucst_has_data", has_data, 1);
    chk("ucst_hdr_last", last, 0);
    hdr_ready = 1'b1;
    step();
    hdr_ready = 1'b0;
    chk("ucst_cred_full", cred_full, 1);
    chk("ucst_hdr_v_off", hdr_v, 0);
    chk("ucst_b0_v", data_v, 1);
    chk("ucst_b0", data, 32'h5566_7788);
    chk("ucst_b0_last", last, 0);
    data_ready = 1'b1;
    step();
    chk("ucst_b1", data, 32'h1122_3344);
    chk("ucst_b1_last", last, 1);
    step();
    data_ready = 1'b0;
    chk("ucst_done_v", data_v, 0);
    chk("ucst_done_data", data, 0);
    chk("ucst_done_q", q_empty, 1);

    // Credit stall, then one return releases the header
    req = mk_req(4'd3, 4'd0, 3'd2, 40'h2000, 64'h0); req_v = 1'b1;
    step();
    req_v = 1'b0;
    chk("stall_hdr_v", hdr_v, 0);
    chk("stall_q_empty", q_empty, 0);
    comp = 1'b1;
    step();
    comp = 1'b0;
    chk("release_cred_full", cred_full, 0);
    chk("release_hdr_v", hdr_v, 1);
    chk("ucld_hdr", hdr, mk_hdr(4'd2, 4'd0, 40'h2000, 3'd2, 6'd0, 3'd0, 1'b0));
    chk("ucld_last", last, 1);
    // Return coincident with a header handshake leaves the count at 1
    hdr_ready = 1'b1; ucomp = 1'b1;
    step();
    hdr_ready = 1'b0; ucomp = 1'b0;
    chk("simul_cred_full", cred_full, 0);
    chk("simul_cred_empty", cred_empty, 0);
    chk("simul_q_empty", q_empty, 1);

    // Fill the queue, then push the cycle after a pop
    req = mk_req(4'd0, 4'd0, 3'd3, 40'h80_0000_0047, 64'h0); way = 3'd5; req_v = 1'b1;
    step();
    req = mk_req(4'd4, 4'd4, 3'd3, 40'h3010, 64'hAAAA_BBBB_CCCC_DDDD); way = 3'd0;
    chk("fill_ready1", req_ready, 1);
    step();
    req = mk_req(4'd3, 4'd0, 3'd0, 40'h4000, 64'h0);
    chk("full_ready", req_ready, 0);
    chk("wrmiss_hdr", hdr, mk_hdr(4'd1, 4'd0, 40'h80_0000_0044, 3'd6, 6'd1, 3'd5, 1'b0));
    hdr_ready = 1'b1;
    step();
    hdr_ready = 1'b0;
    chk("after_pop_ready", req_ready, 1);
    chk("after_pop_cred_full", cred_full, 1);
    chk("after_pop_hdr_v", hdr_v, 0);
    step();
    req_v = 1'b0;
    chk("refill_ready", req_ready, 0);

    // AMO header and first beat, then reset mid-burst
    comp = 1'b1;
    step();
    comp = 1'b0;
    chk("amo_hdr", hdr, mk_hdr(4'd4, 4'd4, 40'h3010, 3'd3, 6'd0, 3'd0, 1'b0));
    chk("amo_has_data", has_data, 1);
    hdr_ready = 1'b1;
    step();
    hdr_ready = 1'b0;
    chk("amo_b0_v", data_v, 1);
    chk("amo_b0", data, 32'hCCCC_DDDD);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_mid_data_v", data_v, 0);
    chk("rst_mid_hdr_v", hdr_v, 0);
    chk("rst_mid_q_empty", q_empty, 1);
    chk("rst_mid_cred_empty", cred_empty, 1);
    chk("rst_mid_ready", req_ready, 0);
    step(); step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
